tone_oscillator: RTL and testbench
==================================

# tone_oscillator

Parametrised multi-waveform voice oscillator: the successor to the fixed 50 %-duty square generator. It produces square/pulse, sawtooth and triangle waves from a period expressed in clk cycles. Period changes are glitch-free, applied only at a waveform-cycle boundary. Output is volume-scaled, unsigned offset-binary and feeds the voice mixer.

## Interface
- OUT_W, 24: output sample width.
- PERIOD_W, 23: period width, in clk cycles.

- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- enable  in  1  voice gate; low forces silence.
- period  in  PERIOD_W  waveform period in clk cycles; values <2 mean silence.
- mode  in  2  00 square/pulse, 01 saw, 10 triangle, 11 reserved (same as 00).
- duty  in  8  pulse high fraction, duty/256; 128 = 50 %.
- volume  in  7  0..127 linear gain.
- value  out  OUT_W  registered sample.
- cycle_start  out  1  one-cycle pulse, aligned with the first sample of each waveform cycle.
- active  out  1  high while running a valid period.

## Operation
- Step divider (sequential, restoring, 1 quotient bit/clk):
  - Computes step = floor((2^OUT_W-1)/P).
  - Starts when idle and period != last target; latches target = period.
  - Done exactly OUT_W cycles after the start edge; then sets pend_valid with pend_P/pend_step.
  - A period change while busy waits until completion, then starts again.
- Load rule: pend_valid transfers pend_P/pend_step into act_P/act_step, and clears pend_valid, when:
  - ph == act_P-1 (cycle boundary), or
  - active == 0.
  - On load, ph <= 0 and ramp <= 0.
- If the loaded act_P < 2, active <= 0.
- Run, when active && enable:
  - ph increments and wraps to 0 after act_P-1.
  - ramp += act_step; reset to 0 on wrap.
- Raw waveform:
  - Square: all-ones if ph < (act_P*duty)>>8, else 0.
  - Saw: ramp.
  - Triangle: ramp[OUT_W-1] ? ~(ramp<<1) : (ramp<<1), truncated to OUT_W.
- Scaling: value = floor(raw*volume/127), exact, using a full-width product.
- Silence: when enable == 0 or active == 0:
  - value = 0, ph and ramp held at 0, cycle_start = 0.
  - The divider and pending load still operate.
- Mode, duty and volume take effect on the next sample, with no boundary wait.

## Timing
- Reset values: value = 0, cycle_start = 0, active = 0, ph = ramp = 0, pend_valid = 0, divider idle, last target = 0.
- value and cycle_start lag ph/ramp by 1 clk.
- Startup, counting the first edge with reset low as edge 1:
  - Edge 1: divider start.
  - Edge OUT_W+1: pend_valid.
  - Edge OUT_W+2: load, ph = 0.
  - Edge OUT_W+3: first cycle_start and first non-zero sample.
- Period change mid-cycle: the current cycle completes at the old period, and the new period starts at the first boundary after the divider finishes.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight division is discarded.
- enable falling: value = 0 on the following edge. enable rising: ph restarts at 0, and cycle_start pulses one edge later.

## Test plan
- Square: period = 4, duty = 128, volume = 127, mode = 0 -> steady value sequence FFFFFF, FFFFFF, 000000, 000000; cycle_start on each first FFFFFF; first pulse at edge 27.
- Saw: period = 4, volume = 127, mode = 1 -> 000000, 3FFFFF, 7FFFFE, BFFFFD repeating.
- Triangle: period = 4, mode = 2 -> 000000, 7FFFFE, FFFFFC, 800005 repeating.
- Volume: square, volume = 64 -> high level 8454659 (floor(16777215*64/127)), low level 0; volume = 0 -> constant 0.
- Glitch-free change: period 8 -> 4 written at ph = 2 -> old 8-cycle period continues until the divider completes; the first 4-cycle period starts exactly at an 8-boundary, and no cycle_start spacing other than 8 or 4 ever appears.
- Boundaries:
  - period = 1 -> active = 0, value = 0.
  - duty = 0 -> constant 0; duty = 255, period = 4 -> 3 high samples, 1 low.
  - enable low for 5 cycles -> value 0 throughout; restart yields cycle_start one edge after enable rises.
  - reset asserted mid-division -> active = 0, and the next startup timing matches the reset case.

Source files
------------

// File: rtl/tone_oscillator.sv
// Multi-waveform voice oscillator: square/pulse, saw and triangle generated from a period in clk
// cycles. A serial divider derives the ramp step; new periods load only at a cycle boundary.
module tone_oscillator #(
  parameter int unsigned OUT_W    = 24,
  parameter int unsigned PERIOD_W = 23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          mode,
  input  logic [7:0]          duty,
  input  logic [6:0]          volume,
  output logic [OUT_W-1:0]    value,
  output logic                cycle_start,
  output logic                active
);

  localparam int unsigned CntW = $clog2(OUT_W + 1);

  // Divider state
  logic                div_busy;
  logic [CntW-1:0]     div_cnt;
  logic [PERIOD_W-1:0] div_rem;
  logic [OUT_W-2:0]    div_quo;
  logic [PERIOD_W-1:0] target;

  // Pending and active period/step
  logic                pend_valid;
  logic [PERIOD_W-1:0] pend_p;
  logic [OUT_W-1:0]    pend_step;
  logic [PERIOD_W-1:0] act_p;
  logic [OUT_W-1:0]    act_step;

  // Phase counter and ramp accumulator
  logic [PERIOD_W-1:0] ph;
  logic [OUT_W-1:0]    ramp;

  // Combinational helpers
  logic [PERIOD_W:0]   rem_shift;
  logic                rem_ge;
  logic [PERIOD_W-1:0] rem_next;
  logic [OUT_W-1:0]    quo_next;
  logic                div_last;
  logic                boundary;
  logic                do_load;
  logic                run;
  logic [PERIOD_W+7:0] pulse_prod;
  logic                sq_high;
  logic [OUT_W-1:0]    tri_shift;
  logic [OUT_W-1:0]    raw;
  logic [OUT_W+6:0]    prod;
  logic [OUT_W-1:0]    scaled;

  // Restoring divide step; the dividend is all ones, so every shifted-in bit is 1
  always_comb begin
    rem_shift = {div_rem, 1'b1};
    rem_ge    = rem_shift >= {1'b0, target};
    rem_next  = PERIOD_W'(rem_ge ? rem_shift - {1'b0, target} : rem_shift);
    quo_next  = {div_quo, rem_ge};
    div_last  = div_cnt == CntW'(OUT_W - 1);
  end

  // Load/run decisions
  always_comb begin
    boundary = ph == act_p - PERIOD_W'(1);
    do_load  = pend_valid && (boundary || !active);
    run      = active && enable;
  end

  // Raw waveform selection and exact volume scaling
  always_comb begin
    pulse_prod = {8'b0, act_p} * {{PERIOD_W{1'b0}}, duty};
    sq_high    = {8'b0, ph} < (pulse_prod >> 8);
    tri_shift  = {ramp[OUT_W-2:0], 1'b0};
    raw        = '0;
    case (mode)
      2'b01:   raw = ramp;
      2'b10:   raw = ramp[OUT_W-1] ? ~tri_shift : tri_shift;
      default: raw = sq_high ? {OUT_W{1'b1}} : '0;
    endcase
    prod   = {7'b0, raw} * {{OUT_W{1'b0}}, volume};
    scaled = OUT_W'(prod / (OUT_W + 7)'(127));
  end

  // Serial divider and pending-step handoff
  always_ff @(posedge clk) begin
    if (reset) begin
      div_busy   <= 1'b0;
      div_cnt    <= '0;
      div_rem    <= '0;
      div_quo    <= '0;
      target     <= '0;
      pend_valid <= 1'b0;
      pend_p     <= '0;
      pend_step  <= '0;
    end else begin
      if (do_load) pend_valid <= 1'b0;
      if (div_busy) begin
        div_rem <= rem_next;
        div_quo <= quo_next[OUT_W-2:0];
        div_cnt <= div_cnt + CntW'(1);
        if (div_last) begin
          // A fresh result overrides a same-edge load clear
          div_busy   <= 1'b0;
          pend_valid <= 1'b1;
          pend_p     <= target;
          pend_step  <= quo_next;
        end
      end else if (period != target) begin
        div_busy <= 1'b1;
        target   <= period;
        div_cnt  <= '0;
        div_rem  <= '0;
        div_quo  <= '0;
      end
    end
  end

  // Active period load, phase and ramp advance
  always_ff @(posedge clk) begin
    if (reset) begin
      act_p    <= '0;
      act_step <= '0;
      active   <= 1'b0;
      ph       <= '0;
      ramp     <= '0;
    end else if (do_load) begin
      act_p    <= pend_p;
      act_step <= pend_step;
      active   <= pend_p >= PERIOD_W'(2);
      ph       <= '0;
      ramp     <= '0;
    end else if (run) begin
      if (boundary) begin
        ph   <= '0;
        ramp <= '0;
      end else begin
        ph   <= ph + PERIOD_W'(1);
        ramp <= ramp + act_step;
      end
    end else begin
      ph   <= '0;
      ramp <= '0;
    end
  end

  // Registered sample and cycle marker, one clk behind ph/ramp
  always_ff @(posedge clk) begin
    if (reset) begin
      value       <= '0;
      cycle_start <= 1'b0;
    end else begin
      value       <= run ? scaled : '0;
      cycle_start <= run && (ph == '0);
    end
  end

endmodule

// File: tb/tb_tone_oscillator.sv
// Self-checking bench for tone_oscillator: directed waveforms plus randomized settings checked
// against a phase-indexed reference model.
module tb_tone_oscillator;

  localparam int OW = 24;
  localparam int PW = 23;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    duty = 8'd128;
  logic [6:0]    volume = 7'd127;
  logic [OW-1:0] value;
  logic          cycle_start;
  logic          active;

  int checks = 0;
  int errors = 0;
  int cur_p  = 4;   // period the model believes is active
  int k      = 0;   // phase index of the next displayed sample

  tone_oscillator #(
    .OUT_W   (OW),
    .PERIOD_W(PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .period     (period),
    .mode       (mode),
    .duty       (duty),
    .volume     (volume),
    .value      (value),
    .cycle_start(cycle_start),
    .active     (active)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sample at phase idx of a period p waveform, from the waveform definitions.
  function automatic logic [OW-1:0] exp_value(int m, int d, int v, int p, int idx);
    longint step, rmp, raw, t;
    step = 64'hFFFFFF / p;
    rmp  = idx * step;
    case (m)
      1: raw = rmp;
      2: begin
        t   = (rmp * 2) & 64'hFFFFFF;
        raw = (rmp >= 64'h800000) ? (~t & 64'hFFFFFF) : t;
      end
      default: raw = (idx < (p * d) / 256) ? 64'hFFFFFF : 64'h0;
    endcase
    return OW'((raw * v) / 127);
  endfunction

  task automatic test_reset();
    reset = 1'b1; period = PW'(4); mode = 2'd0; duty = 8'd128; volume = 7'd127; enable = 1'b1;
    repeat (3) tick();
    checks++; if (value !== '0) begin errors++; $display("FAIL reset_value: got %h want 0", value); end
    checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", cycle_start); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
  endtask

  task automatic test_startup();
    reset = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      tick();
      checks++;
      if (value !== '0 || cycle_start !== 1'b0) begin
        errors++; $display("FAIL startup_quiet edge %0d: value=%h cs=%b want 0/0", e, value, cycle_start);
      end
    end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL startup_active: got %b want 1", active); end
    tick();
    checks++; if (cycle_start !== 1'b1) begin errors++; $display("FAIL startup_cs edge 27: got %b want 1", cycle_start); end
    checks++; if (value !== 24'hFFFFFF) begin errors++; $display("FAIL startup_value edge 27: got %h want ffffff", value); end
    cur_p = 4; k = 1;
  endtask

  task automatic test_square();
    logic [OW-1:0] tab [4];
    tab = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
    mode = 2'd0; duty = 8'd128; volume = 7'd127;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (value !== tab[k]) begin errors++; $display("FAIL square k=%0d: got %h want %h", k, value, tab[k]); end
      checks++; if (cycle_start !== logic'(k == 0)) begin errors++; $display("FAIL square_cs k=%0d: got %b", k, cycle_start); end
      k = (k + 1) % cur_p;
    end
  endtask

  task automatic test_saw();
    logic [OW-1:0] tab [4];
    tab = '{24'h000000, 24'h3FFFFF, 24'h7FFFFE, 24'hBFFFFD};
    mode = 2'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (value !== tab[k]) begin errors++; $display("FAIL saw k=%0d: got %h want %h", k, value, tab[k]); end
      k = (k + 1) % cur_p;
    end
  endtask

  task automatic test_triangle();
    logic [OW-1:0] tab [4];
    tab = '{24'h000000, 24'h7FFFFE, 24'hFFFFFC, 24'h800005};
    mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (value !== tab[k]) begin errors++; $display("FAIL triangle k=%0d: got %h want %h", k, value, tab[k]); end
      k = (k + 1) % cur_p;
    end
  endtask

  task automatic test_volume();
    logic [OW-1:0] want;
    mode = 2'd0; duty = 8'd128; volume = 7'd64;
    for (int i = 0; i < 8; i++) begin
      tick();
      want = (k < 2) ? OW'(8454659) : '0;
      checks++; if (value !== want) begin errors++; $display("FAIL volume64 k=%0d: got %0d want %0d", k, value, want); end
      k = (k + 1) % cur_p;
    end
    volume = 7'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (value !== '0) begin errors++; $display("FAIL volume0 k=%0d: got %h want 0", k, value); end
      k = (k + 1) % cur_p;
    end
    volume = 7'd127;
  endtask

  task automatic test_duty();
    logic [OW-1:0] want;
    mode = 2'd0; duty = 8'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (value !== '0) begin errors++; $display("FAIL duty0 k=%0d: got %h want 0", k, value); end
      k = (k + 1) % cur_p;
    end
    duty = 8'd255;
    for (int i = 0; i < 8; i++) begin
      tick();
      want = (k < 3) ? 24'hFFFFFF : 24'h0;
      checks++; if (value !== want) begin errors++; $display("FAIL duty255 k=%0d: got %h want %h", k, value, want); end
      k = (k + 1) % cur_p;
    end
  endtask

  task automatic test_random_samples();
    logic [OW-1:0] want;
    for (int i = 0; i < 200; i++) begin
      mode = 2'($urandom_range(0, 3)); duty = 8'($urandom_range(0, 255)); volume = 7'($urandom_range(0, 127));
      tick();
      want = exp_value(int'(mode), int'(duty), int'(volume), cur_p, k);
      checks++; if (value !== want) begin errors++; $display("FAIL random_sample m=%0d d=%0d v=%0d k=%0d: got %h want %h", mode, duty, volume, k, value, want); end
      checks++; if (cycle_start !== logic'(k == 0)) begin errors++; $display("FAIL random_cs k=%0d: got %b", k, cycle_start); end
      k = (k + 1) % cur_p;
    end
  endtask

  // Writes a new period; the old period keeps running until the first boundary after the divider
  // result is pending (26 edges after the write at the earliest).
  task automatic test_period_change(int new_p);
    logic [OW-1:0] want;
    bit            switched;
    int            n_ticks;
    switched = 1'b0;
    n_ticks  = 26 + cur_p + 2 * new_p;
    period   = PW'(new_p);
    for (int n = 1; n <= n_ticks; n++) begin
      tick();
      want = exp_value(int'(mode), int'(duty), int'(volume), cur_p, k);
      checks++; if (value !== want) begin errors++; $display("FAIL period_change p=%0d n=%0d k=%0d: got %h want %h", cur_p, n, k, value, want); end
      checks++; if (cycle_start !== logic'(k == 0)) begin errors++; $display("FAIL period_change_cs p=%0d n=%0d k=%0d: got %b", cur_p, n, k, cycle_start); end
      if (!switched && n >= 26 && k == cur_p - 1) begin
        switched = 1'b1; cur_p = new_p; k = 0;
      end else begin
        k = (k + 1) % cur_p;
      end
    end
  endtask

  task automatic test_glitch_free();
    logic [OW-1:0] want;
    mode = 2'd0; duty = 8'd128; volume = 7'd127;
    test_period_change(8);
    // Advance until the DUT phase counter sits at 2
    for (int i = 0; i < 16 && k != 2; i++) begin
      tick();
      want = exp_value(0, 128, 127, cur_p, k);
      checks++; if (value !== want) begin errors++; $display("FAIL glitch_align k=%0d: got %h want %h", k, value, want); end
      k = (k + 1) % cur_p;
    end
    test_period_change(4);
  endtask

  task automatic test_random_periods();
    for (int i = 0; i < 4; i++) begin
      mode = 2'($urandom_range(0, 3)); duty = 8'($urandom_range(0, 255)); volume = 7'($urandom_range(1, 127));
      test_period_change(int'($urandom_range(2, 40)));
    end
  endtask

  task automatic test_enable();
    logic [OW-1:0] want;
    mode = 2'd0; duty = 8'd128; volume = 7'd127;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (value !== '0 || cycle_start !== 1'b0) begin errors++; $display("FAIL enable_low %0d: value=%h cs=%b want 0/0", i, value, cycle_start); end
    end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL enable_low_active: got %b want 1", active); end
    enable = 1'b1; k = 0;
    for (int i = 0; i < 2 * cur_p; i++) begin
      tick();
      want = exp_value(0, 128, 127, cur_p, k);
      checks++; if (value !== want) begin errors++; $display("FAIL enable_restart k=%0d: got %h want %h", k, value, want); end
      checks++; if (cycle_start !== logic'(k == 0)) begin errors++; $display("FAIL enable_restart_cs k=%0d: got %b", k, cycle_start); end
      k = (k + 1) % cur_p;
    end
  endtask

  task automatic test_period_one();
    period = PW'(1);
    repeat (26 + cur_p + 2) tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL period1_active: got %b want 0", active); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (value !== '0 || cycle_start !== 1'b0) begin errors++; $display("FAIL period1_silent %0d: value=%h cs=%b", i, value, cycle_start); end
    end
    // Restart from inactive follows the startup timing
    period = PW'(4);
    for (int e = 1; e <= 26; e++) begin
      tick();
      checks++; if (value !== '0 || cycle_start !== 1'b0) begin errors++; $display("FAIL period1_restart_quiet edge %0d: value=%h cs=%b", e, value, cycle_start); end
    end
    tick();
    checks++; if (cycle_start !== 1'b1 || value !== 24'hFFFFFF) begin errors++; $display("FAIL period1_restart edge 27: cs=%b value=%h want 1/ffffff", cycle_start, value); end
    cur_p = 4; k = 1;
  endtask

  task automatic test_reset_mid_division();
    logic [OW-1:0] want;
    mode = 2'd1; duty = 8'd128; volume = 7'd127;
    period = PW'(6);
    for (int i = 0; i < 10; i++) begin
      tick();
      want = exp_value(1, 128, 127, cur_p, k);
      checks++; if (value !== want) begin errors++; $display("FAIL middiv_run k=%0d: got %h want %h", k, value, want); end
      k = (k + 1) % cur_p;
    end
    reset = 1'b1;
    tick();
    checks++; if (active !== 1'b0 || value !== '0 || cycle_start !== 1'b0) begin errors++; $display("FAIL middiv_reset: active=%b value=%h cs=%b want 0/0/0", active, value, cycle_start); end
    reset = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      tick();
      checks++; if (value !== '0 || cycle_start !== 1'b0) begin errors++; $display("FAIL middiv_quiet edge %0d: value=%h cs=%b", e, value, cycle_start); end
    end
    tick();
    checks++; if (cycle_start !== 1'b1) begin errors++; $display("FAIL middiv_cs edge 27: got %b want 1", cycle_start); end
    cur_p = 6; k = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      want = exp_value(1, 128, 127, cur_p, k);
      checks++; if (value !== want) begin errors++; $display("FAIL middiv_saw k=%0d: got %h want %h", k, value, want); end
      checks++; if (cycle_start !== logic'(k == 0)) begin errors++; $display("FAIL middiv_saw_cs k=%0d: got %b", k, cycle_start); end
      k = (k + 1) % cur_p;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_square();
    test_saw();
    test_triangle();
    test_volume();
    test_duty();
    test_random_samples();
    test_glitch_free();
    test_random_periods();
    test_enable();
    test_period_one();
    test_reset_mid_division();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
